alu_control_mc: RTL and testbench

- Parametrised, registered successor to the single-cycle ALU control decoder.
- Decodes ALUOp and the funct field into the ALU control code, the jump-register flag and an illegal-op flag, with one-cycle registered latency.
- Adds a sequencer for multi-cycle mult/div operations, including busy tracking, HI/LO write strobe and pipeline stall generation.
- Sits between the main control unit / ID stage and the EX-stage ALU and mult/div unit.

---
 rtl/alu_control_mc.sv | 173 +++++++++++++++++
 tb/tb_alu_control_mc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU control decoder with a multi-cycle
// mult/div sequencer.
//
// Decodes alu_op/funct into the ALU control code, jump-register flag,
// illegal-op flag and HI/LO read select. The result is registered, so it
// appears one cycle after the instruction is accepted. Accepted mult/div
// ops start a sequence: the RUN phase lasts MD_CYCLES cycles, then a
// one-cycle DONE phase pulses hilo_we. While that sequence is busy,
// further mult/div or mfhi/mflo instructions stall. Other instructions
// continue to flow.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   valid_in      instruction present on alu_op/funct
//   alu_op        operation class from main control
//   funct         R-type function field
//   stall         (comb) instruction not accepted, upstream must hold
//   valid_out     registered decode outputs valid
//   alu_ctr       ALU control code (holds when nothing is accepted)
//   jump_register jr decoded
//   illegal       unsupported alu_op/funct combination
//   hilo_rd       01 = mflo, 10 = mfhi, 00 = none
//   md_start      one-cycle pulse on the first RUN cycle
//   md_op         0 mult, 1 multu, 2 div, 3 divu (held until next start)
//   md_busy       sequence in RUN or DONE
//   hilo_we       one-cycle HI/LO write strobe in DONE
module alu_control_mc #(
  parameter int CTR_W     = 4,
  parameter int FUNCT_W   = 6,
  parameter int MD_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [2:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               stall,
  output logic               valid_out,
  output logic [CTR_W-1:0]   alu_ctr,
  output logic               jump_register,
  output logic               illegal,
  output logic [1:0]         hilo_rd,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_busy,
  output logic               hilo_we
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } md_state_t;

  md_state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [CTR_W-1:0] dec_ctr;
  logic             dec_jr;
  logic             dec_ill;
  logic [1:0]       dec_hilo;
  logic             dec_md;
  logic [1:0]       dec_md_op;
  logic             dec_mf;
  logic             accept;

  always_comb begin
    dec_ctr   = CTR_W'(2);
    dec_jr    = 1'b0;
    dec_ill   = 1'b0;
    dec_hilo  = 2'b00;
    dec_md    = 1'b0;
    dec_md_op = 2'b00;
    dec_mf    = 1'b0;
    unique case (alu_op)
      3'd0: dec_ctr = CTR_W'(2);
      3'd1: dec_ctr = CTR_W'(6);
      3'd2: begin
        case (funct)
          FUNCT_W'(32), FUNCT_W'(33): dec_ctr = CTR_W'(2);
          FUNCT_W'(34), FUNCT_W'(35): dec_ctr = CTR_W'(6);
          FUNCT_W'(36): dec_ctr = CTR_W'(0);
          FUNCT_W'(37): dec_ctr = CTR_W'(1);
          FUNCT_W'(38): dec_ctr = CTR_W'(3);
          FUNCT_W'(39): dec_ctr = CTR_W'(12);
          FUNCT_W'(42): dec_ctr = CTR_W'(7);
          FUNCT_W'(43): dec_ctr = CTR_W'(8);
          FUNCT_W'(8):  dec_jr  = 1'b1;
          FUNCT_W'(24), FUNCT_W'(25), FUNCT_W'(26), FUNCT_W'(27): begin
            dec_md    = 1'b1;
            // funct 24..27 map directly onto md_op 0..3 via the low bits
            dec_md_op = funct[1:0];
          end
          FUNCT_W'(16): begin
            dec_hilo = 2'b10;
            dec_mf   = 1'b1;
          end
          FUNCT_W'(18): begin
            dec_hilo = 2'b01;
            dec_mf   = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      3'd3: dec_ctr = CTR_W'(1);
      3'd4: dec_ctr = CTR_W'(0);
      3'd5: dec_ctr = CTR_W'(7);
      3'd6: dec_ctr = CTR_W'(8);
      default: dec_ill = 1'b1;
    endcase
  end

  assign stall  = valid_in && md_busy && (dec_md || dec_mf);
  assign accept = valid_in && !stall;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        if (accept && dec_md) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(MD_CYCLES - 1);
        end
      end
      S_RUN: begin
        if (cnt == '0) state_d = S_DONE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      valid_out     <= 1'b0;
      alu_ctr       <= '0;
      jump_register <= 1'b0;
      illegal       <= 1'b0;
      hilo_rd       <= 2'b00;
      md_start      <= 1'b0;
      md_op         <= 2'b00;
      md_busy       <= 1'b0;
      hilo_we       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      // Status flags are registered from the next state so they line up
      // with the state they describe without extra decode on the outputs.
      md_start  <= (state == S_IDLE) && (state_d == S_RUN);
      md_busy   <= (state_d != S_IDLE);
      hilo_we   <= (state_d == S_DONE);
      if ((state == S_IDLE) && (state_d == S_RUN)) md_op <= dec_md_op;
      valid_out <= accept;
      if (accept) begin
        alu_ctr       <= dec_ctr;
        jump_register <= dec_jr;
        illegal       <= dec_ill;
        hilo_rd       <= dec_hilo;
      end else begin
        jump_register <= 1'b0;
        illegal       <= 1'b0;
        hilo_rd       <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Testbench for alu_control_mc (MD_CYCLES=4): directed scenarios followed
// by randomized traffic, all checked against a cycle-indexed reference
// model. The mult/div sequence is modelled as a time window after the
// acceptance cycle.
module tb_alu_control_mc;

  localparam int MD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       stall;
  logic       valid_out;
  logic [3:0] alu_ctr;
  logic       jump_register;
  logic       illegal;
  logic [1:0] hilo_rd;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy;
  logic       hilo_we;

  alu_control_mc #(.CTR_W(4), .FUNCT_W(6), .MD_CYCLES(MD)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_op(alu_op),
    .funct(funct), .stall(stall), .valid_out(valid_out), .alu_ctr(alu_ctr),
    .jump_register(jump_register), .illegal(illegal), .hilo_rd(hilo_rd),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int cyc     = 0;
  int t0      = -100;   // cycle in which the last md op was accepted
  int e_vo    = 0;
  int e_ctr   = 0;
  int e_jr    = 0;
  int e_ill   = 0;
  int e_hilo  = 0;
  int e_mdop  = 0;
  int n_stall = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit busy_at(input int c);
    return (c >= t0 + 1) && (c <= t0 + MD + 1);
  endfunction

  function automatic void ref_decode(input int op, input int fn,
                                     output int ctr, output int jr,
                                     output int ill, output int hilo,
                                     output int is_md, output int is_mf,
                                     output int mdop);
    int op_ctr [8] = '{2, 6, 2, 1, 0, 7, 8, 2};
    ctr = op_ctr[op]; jr = 0; ill = (op == 7); hilo = 0;
    is_md = 0; is_mf = 0; mdop = 0;
    if (op == 2) begin
      if (fn == 32 || fn == 33)      ctr = 2;
      else if (fn == 34 || fn == 35) ctr = 6;
      else if (fn == 36)             ctr = 0;
      else if (fn == 37)             ctr = 1;
      else if (fn == 38)             ctr = 3;
      else if (fn == 39)             ctr = 12;
      else if (fn == 42)             ctr = 7;
      else if (fn == 43)             ctr = 8;
      else if (fn == 8)              jr = 1;
      else if (fn >= 24 && fn <= 27) begin is_md = 1; mdop = fn - 24; end
      else if (fn == 16)             begin hilo = 2; is_mf = 1; end
      else if (fn == 18)             begin hilo = 1; is_mf = 1; end
      else                           ill = 1;
    end
  endfunction

  task automatic step(input bit r, input bit v, input int op, input int fn);
    int ctr, jr, ill, hilo, is_md, is_mf, mdop;
    bit exp_stall, acc;
    @(negedge clk);
    rst = r; valid_in = v; alu_op = 3'(op); funct = 6'(fn);
    ref_decode(op, fn, ctr, jr, ill, hilo, is_md, is_mf, mdop);
    exp_stall = v && busy_at(cyc) && (is_md != 0 || is_mf != 0);
    acc = v && !exp_stall;
    #1;
    check("stall", int'(stall), int'(exp_stall));
    if (stall) n_stall++;
    if (r) begin
      e_vo = 0; e_ctr = 0; e_jr = 0; e_ill = 0; e_hilo = 0; e_mdop = 0;
      t0 = -100;
    end else begin
      e_vo = acc;
      if (acc) begin
        e_ctr = ctr; e_jr = jr; e_ill = ill; e_hilo = hilo;
      end else begin
        e_jr = 0; e_ill = 0; e_hilo = 0;
      end
      if (acc && is_md != 0) begin
        t0 = cyc; e_mdop = mdop;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    check("valid_out", int'(valid_out), e_vo);
    check("alu_ctr", int'(alu_ctr), e_ctr);
    check("jump_register", int'(jump_register), e_jr);
    check("illegal", int'(illegal), e_ill);
    check("hilo_rd", int'(hilo_rd), e_hilo);
    check("md_op", int'(md_op), e_mdop);
    check("md_start", int'(md_start), int'(cyc == t0 + 1));
    check("md_busy", int'(md_busy), int'(busy_at(cyc)));
    check("hilo_we", int'(hilo_we), int'(cyc == t0 + MD + 1));
  endtask

  int sweep_fn  [8] = '{32, 34, 36, 37, 38, 39, 42, 43};
  int sweep_ctr [8] = '{2, 6, 0, 1, 3, 12, 7, 8};
  int pick      [14] = '{8, 16, 18, 24, 25, 26, 27, 32, 33, 34, 36, 39, 42, 43};

  initial begin
    rst = 1'b1; valid_in = 1'b0; alu_op = '0; funct = '0;
    repeat (2) @(posedge clk);

    // reset values
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // R-type sweep, back to back
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2, sweep_fn[i]);
      check("sweep_ctr", int'(alu_ctr), sweep_ctr[i]);
      check("sweep_vo", int'(valid_out), 1);
    end

    // jr, illegal funct, reserved alu_op
    step(0, 1, 2, 8);
    check("jr_flag", int'(jump_register), 1);
    step(0, 1, 2, 5);
    check("ill_funct", int'(illegal), 1);
    step(0, 1, 7, 0);
    check("ill_op", int'(illegal), 1);
    step(0, 0, 0, 0);

    // div with an add flowing through while busy
    step(0, 1, 2, 26);
    step(0, 0, 0, 0);
    step(0, 1, 2, 32);
    repeat (5) step(0, 0, 0, 0);

    // mfhi hazard: offered from the 2nd cycle of the sequence onward
    step(0, 1, 2, 26);
    step(0, 0, 0, 0);
    n_stall = 0;
    repeat (5) step(0, 1, 2, 16);
    check("mfhi_stalls", n_stall, 4);
    check("mfhi_hilo", int'(hilo_rd), 2);
    repeat (2) step(0, 0, 0, 0);

    // second mult offered during RUN
    step(0, 1, 2, 26);
    repeat (6) step(0, 1, 2, 24);
    check("mult_op", int'(md_op), 0);
    repeat (6) step(0, 0, 0, 0);

    // reset in the middle of a sequence
    step(0, 1, 2, 27);
    step(0, 0, 0, 0);
    step(0, 1, 2, 16);
    step(1, 1, 2, 16);
    check("rst_busy", int'(md_busy), 0);
    repeat (6) step(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v;
      int op, fn;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 4) != 0);
      op = ($urandom_range(0, 1) == 0) ? 2 : int'($urandom_range(0, 7));
      fn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                       : pick[$urandom_range(0, 13)];
      step(r, v, op, fn);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
